// File: rtl/serial_fila_pkg.sv
// Shared types and helpers for the serial receiver with integrated queue.
package serial_fila_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        READY,
        STALL
    } rx_state_t;

    // Bit index that the cnt-th received bit occupies in the assembled word.
    function automatic int unsigned bit_pos(input int unsigned width,
                                            input int unsigned cnt,
                                            input bit          msb_first);
        return msb_first ? (width - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/serial_fila_param_if.sv
// Serial input, word handshake and queue signals of serial_fila_param.
interface serial_fila_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic                     data_serial;
    logic                     write_serial;
    logic                     ack_serial;
    logic                     dequeue_fila;
    logic [WIDTH-1:0]         data_parallel;
    logic                     data_ready;
    logic                     status_busy;
    logic [$clog2(DEPTH):0]   fila_len;
    logic [WIDTH-1:0]         fila_out;
    logic                     fila_full;
    logic                     fila_empty;
    logic                     overrun;

    modport master (
        output data_serial, write_serial, ack_serial, dequeue_fila,
        input  data_parallel, data_ready, status_busy, fila_len, fila_out,
               fila_full, fila_empty, overrun
    );

    modport slave (
        input  data_serial, write_serial, ack_serial, dequeue_fila,
        output data_parallel, data_ready, status_busy, fila_len, fila_out,
               fila_full, fila_empty, overrun
    );
endinterface

// File: rtl/serial_fila_param_fila_circular.sv
// Circular word queue with registered first-word-fall-through head and occupancy flags.
module fila_circular #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock1MHz,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] len,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
    logic [LEN_W-1:0] len_next;
    logic [WIDTH-1:0] head_next;
    logic             push_ok, pop_ok;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        rd_next  = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
        len_next = len;
        if (push_ok && !pop_ok)
            len_next = len + LEN_W'(1);
        else if (!push_ok && pop_ok)
            len_next = len - LEN_W'(1);
        // The word being written this cycle becomes head when it is the only entry left.
        head_next = '0;
        if (len_next != '0)
            head_next = (push_ok && rd_next == wr_ptr) ? data : mem[rd_next];
    end

    // NOTE: storage is deliberately not reset; the pointers and len alone decide which entries are valid.
    always_ff @(posedge clock1MHz) begin
        if (push_ok)
            mem[wr_ptr] <= data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock1MHz) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            len    <= '0;
            head   <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_next;
            len    <= len_next;
            head   <= head_next;
            full   <= (len_next == LEN_W'(DEPTH));
            empty  <= (len_next == '0);
        end
    end
endmodule

// File: rtl/serial_fila_param.sv
// Serial-to-parallel receiver with ack handshake, backpressure stall and an integrated circular queue.
module serial_fila_param
    import serial_fila_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clock1MHz,
    input  logic               reset,
    serial_fila_param_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int LEN_W = $clog2(DEPTH) + 1;

    rx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_reg, shift_next, data_parallel;
    logic             write_prev, ack_prev, deq_prev;
    logic             wr_ev, ack_ev, deq_ev, push;
    logic             data_ready, status_busy, overrun;
    logic [WIDTH-1:0] fila_out;
    logic [LEN_W-1:0] fila_len;
    logic             fila_full, fila_empty;

    always_comb begin
        wr_ev  = bus.write_serial & ~write_prev;
        ack_ev = bus.ack_serial   & ~ack_prev;
        deq_ev = bus.dequeue_fila & ~deq_prev;
        shift_next = shift_reg;
        shift_next[CNT_W'(bit_pos(WIDTH, 32'(bit_cnt), MSB_FIRST))] = bus.data_serial;
        // Push decisions look only at the registered full flag.
        push = !fila_full && ((state == READY && ack_ev) || state == STALL);
    end

    always_ff @(posedge clock1MHz) begin
        if (reset) begin
            write_prev    <= 1'b0;
            ack_prev      <= 1'b0;
            deq_prev      <= 1'b0;
            state         <= COLLECT;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            data_parallel <= '0;
            data_ready    <= 1'b0;
            status_busy   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            write_prev <= bus.write_serial;
            ack_prev   <= bus.ack_serial;
            deq_prev   <= bus.dequeue_fila;
            if (wr_ev && status_busy)
                overrun <= 1'b1;
            case (state)
                COLLECT: begin
                    if (wr_ev) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                            data_parallel <= shift_next;
                            bit_cnt       <= '0;
                            state         <= READY;
                            data_ready    <= 1'b1;
                            status_busy   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                READY: begin
                    if (ack_ev) begin
                        data_ready <= 1'b0;
                        if (!fila_full) begin
                            state       <= COLLECT;
                            status_busy <= 1'b0;
                        end else begin
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (!fila_full) begin
                        state       <= COLLECT;
                        status_busy <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    fila_circular #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fila (
        .clock1MHz (clock1MHz),
        .reset     (reset),
        .push      (push),
        .pop       (deq_ev),
        .data      (data_parallel),
        .head      (fila_out),
        .len       (fila_len),
        .full      (fila_full),
        .empty     (fila_empty)
    );

    assign bus.data_parallel = data_parallel;
    assign bus.data_ready    = data_ready;
    assign bus.status_busy   = status_busy;
    assign bus.overrun       = overrun;
    assign bus.fila_out      = fila_out;
    assign bus.fila_len      = fila_len;
    assign bus.fila_full     = fila_full;
    assign bus.fila_empty    = fila_empty;
endmodule

// File: tb/tb_serial_fila_param.sv
// Bench for serial_fila_param: MSB-first and LSB-first instances share stimulus and one word-level model.
module tb_serial_fila_param;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ws = 1'b0, ds = 1'b0, ak = 1'b0, dq = 1'b0;
    int   checks_n = 0;
    int   fail_n   = 0;

    always #5 clk = ~clk;

    serial_fila_param_if #(.WIDTH(8), .DEPTH(DEPTH)) if_msb ();
    serial_fila_param_if #(.WIDTH(8), .DEPTH(DEPTH)) if_lsb ();

    assign if_msb.write_serial = ws;
    assign if_msb.data_serial  = ds;
    assign if_msb.ack_serial   = ak;
    assign if_msb.dequeue_fila = dq;
    assign if_lsb.write_serial = ws;
    assign if_lsb.data_serial  = ds;
    assign if_lsb.ack_serial   = ak;
    assign if_lsb.dequeue_fila = dq;

    serial_fila_param #(.WIDTH(8), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
        .clock1MHz (clk), .reset (rst), .bus (if_msb.slave));
    serial_fila_param #(.WIDTH(8), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
        .clock1MHz (clk), .reset (rst), .bus (if_lsb.slave));

    // Word-level model; words are kept in arrival order (first bit = bit 7).
    bit         m_pw, m_pa, m_pd;
    bit         m_held, m_stall, m_ovr;
    int         m_nbits;
    logic [7:0] m_acc, m_word;
    logic [7:0] m_q[$];

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fail_n++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit wr_ev, ack_ev, deq_ev, full, empty, push, pop;
        if (rst) begin
            m_pw = 0; m_pa = 0; m_pd = 0;
            m_held = 0; m_stall = 0; m_ovr = 0;
            m_nbits = 0; m_acc = 0; m_word = 0;
            m_q.delete();
            return;
        end
        wr_ev  = ws && !m_pw;
        ack_ev = ak && !m_pa;
        deq_ev = dq && !m_pd;
        full   = (m_q.size() == DEPTH);
        empty  = (m_q.size() == 0);
        push   = 0;
        if (wr_ev && (m_held || m_stall)) m_ovr = 1;
        if (m_stall) begin
            if (!full) begin push = 1; m_stall = 0; end
        end else if (m_held) begin
            if (ack_ev) begin
                m_held = 0;
                if (!full) push = 1;
                else m_stall = 1;
            end
        end else if (wr_ev) begin
            m_acc = m_acc * 2 + 8'(ds);
            m_nbits++;
            if (m_nbits == 8) begin
                m_word = m_acc; m_held = 1; m_nbits = 0; m_acc = 0;
            end
        end
        pop = deq_ev && !empty;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(m_word);
        m_pw = ws; m_pa = ak; m_pd = dq;
    endtask

    task automatic compare_all();
        logic [7:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 8'h00;
        check("msb.data_parallel", 32'(if_msb.data_parallel), 32'(m_word));
        check("lsb.data_parallel", 32'(if_lsb.data_parallel), 32'(rev8(m_word)));
        check("msb.fila_out",      32'(if_msb.fila_out),      32'(head));
        check("lsb.fila_out",      32'(if_lsb.fila_out),      32'(rev8(head)));
        check("msb.fila_len",      32'(if_msb.fila_len),      32'(m_q.size()));
        check("lsb.fila_len",      32'(if_lsb.fila_len),      32'(m_q.size()));
        check("data_ready",        32'(if_msb.data_ready),    32'(m_held));
        check("status_busy",       32'(if_msb.status_busy),   32'(m_held || m_stall));
        check("overrun",           32'(if_msb.overrun),       32'(m_ovr));
        check("fila_full",         32'(if_msb.fila_full),     32'(m_q.size() == DEPTH));
        check("fila_empty",        32'(if_msb.fila_empty),    32'(m_q.size() == 0));
        check("lsb.status_busy",   32'(if_lsb.status_busy),   32'(m_held || m_stall));
    endtask

    // Inputs change at negedge; model advances at posedge; outputs compared at the next negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_bit(input bit b, input int hold);
        ws = 1'b1; ds = b;
        repeat (hold) tick();
        ws = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w, input int hold);
        for (int i = 7; i >= 0; i--) send_bit(w[i], hold);
    endtask

    task automatic pulse_ack();
        ak = 1'b1; tick(); ak = 1'b0; tick();
    endtask

    task automatic pulse_deq();
        dq = 1'b1; tick(); dq = 1'b0; tick();
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        check("reset.fila_empty", 32'(if_msb.fila_empty), 32'd1);

        send_word(8'hA5, 10);
        check("a5.data_parallel", 32'(if_msb.data_parallel), 32'hA5);
        pulse_ack();
        check("a5.fila_out", 32'(if_msb.fila_out), 32'hA5);
        check("a5.fila_len", 32'(if_msb.fila_len), 32'd1);

        send_word(8'h80, 2);
        check("lsb.first_bit", 32'(if_lsb.data_parallel), 32'h01);
        pulse_ack();
        pulse_deq();
        pulse_deq();

        for (int w = 8'h10; w <= 8'h17; w++) begin
            send_word(8'(w), 1);
            pulse_ack();
        end
        send_word(8'hAA, 1);
        pulse_ack();
        check("stall.busy", 32'(if_msb.status_busy), 32'd1);
        check("stall.len",  32'(if_msb.fila_len),    32'd8);
        dq = 1'b1; tick();
        check("stall.head_after_deq", 32'(if_msb.fila_out), 32'h11);
        dq = 1'b0; tick();
        check("stall.len_after_push", 32'(if_msb.fila_len), 32'd8);
        check("stall.busy_cleared",   32'(if_msb.status_busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("drain.head", 32'(if_msb.fila_out), (i < 7) ? 32'(8'h11 + i) : 32'hAA);
            pulse_deq();
        end

        send_word(8'h5A, 1);
        send_bit(1'b1, 1); send_bit(1'b0, 1); send_bit(1'b1, 1);
        check("ovr.flag", 32'(if_msb.overrun), 32'd1);
        check("ovr.data_parallel", 32'(if_msb.data_parallel), 32'h5A);
        pulse_ack();
        send_word(8'hC3, 1);
        check("ovr.clean_word", 32'(if_msb.data_parallel), 32'hC3);
        pulse_ack();

        send_bit(1'b1, 1); send_bit(1'b1, 1); send_bit(1'b0, 1);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        send_word(8'h3C, 1);
        check("rst.mid_word", 32'(if_msb.data_parallel), 32'h3C);
        pulse_deq();
        check("deq_empty.len", 32'(if_msb.fila_len), 32'd0);
        check("deq_empty.out", 32'(if_msb.fila_out), 32'd0);
        pulse_ack();

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 35) ws = ~ws;
            ds = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 20) ak = ~ak;
            if ($urandom_range(0, 99) < (c < 2000 ? 8 : 30)) dq = ~dq;
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end
endmodule
